// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - streaming 3x3 window generator over two line buffers.
// Optional WINDOW_COORD_EN adds win_x/win_y centre-coordinate outputs.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic [PIX_W-1:0] z1,
  output logic [PIX_W-1:0] z2,
  output logic [PIX_W-1:0] z3,
  output logic [PIX_W-1:0] z4,
  output logic [PIX_W-1:0] z5,
  output logic [PIX_W-1:0] z6,
  output logic [PIX_W-1:0] z7,
  output logic [PIX_W-1:0] z8,
  output logic [PIX_W-1:0] z9,
  output logic             win_valid,
  output logic             frame_done,
  output logic             busy
`ifdef WINDOW_COORD_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [PIX_W-1:0] buf0 [IMG_WIDTH];
  logic [PIX_W-1:0] buf1 [IMG_WIDTH];
  // Two older window columns; z outputs only load on emit so they hold otherwise.
  logic [PIX_W-1:0] top_a, top_b, mid_a, mid_b, bot_a, bot_b;

  logic            active, accept, emit, last;
  logic [CW-1:0]   cur_col;
  logic [RW-1:0]   cur_row;
  logic [PIX_W-1:0] rd0, rd1;

  // A frame_start pixel is (0,0) of the new frame regardless of current counters.
  assign active  = (state == FILL) || (state == STREAM);
  assign accept  = pix_valid && (frame_start || active);
  assign cur_col = frame_start ? '0 : col;
  assign cur_row = frame_start ? '0 : row;
  assign emit    = accept && (cur_col >= CW'(2)) && (cur_row >= RW'(2));
  assign last    = accept && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
  assign rd0     = buf0[cur_col];
  assign rd1     = buf1[cur_col];

  always_ff @(posedge clk) begin
    if (accept) begin
      buf0[cur_col] <= pix_in;
      buf1[cur_col] <= rd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      top_a      <= '0;
      top_b      <= '0;
      mid_a      <= '0;
      mid_b      <= '0;
      bot_a      <= '0;
      bot_b      <= '0;
      z1         <= '0;
      z2         <= '0;
      z3         <= '0;
      z4         <= '0;
      z5         <= '0;
      z6         <= '0;
      z7         <= '0;
      z8         <= '0;
      z9         <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
`ifdef WINDOW_COORD_EN
      win_x      <= '0;
      win_y      <= '0;
`endif
    end else begin
      win_valid  <= emit;
      frame_done <= 1'b0;

      if (accept) begin
        top_a <= top_b;
        top_b <= rd1;
        mid_a <= mid_b;
        mid_b <= rd0;
        bot_a <= bot_b;
        bot_b <= pix_in;
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end else if (frame_start) begin
        col <= '0;
        row <= '0;
      end

      if (emit) begin
        z1 <= top_a;
        z2 <= top_b;
        z3 <= rd1;
        z4 <= mid_a;
        z5 <= mid_b;
        z6 <= rd0;
        z7 <= bot_a;
        z8 <= bot_b;
        z9 <= pix_in;
`ifdef WINDOW_COORD_EN
        win_x <= cur_col - CW'(1);
        win_y <= cur_row - RW'(1);
`endif
      end

      if (frame_start) begin
        state <= FILL;
        busy  <= 1'b1;
      end else begin
        case (state)
          FILL, STREAM: begin
            if (last) begin
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else if (emit) begin
              state <= STREAM;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - directed bench for window_gen_3x3 with an image-array reference model.
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic [7:0] z1, z2, z3, z4, z5, z6, z7, z8, z9;
  logic       win_valid, frame_done, busy;
`ifdef WINDOW_COORD_EN
  logic [1:0] win_x, win_y;
  logic       b_fs = 1'b0, b_pv = 1'b0;
  logic [7:0] b_pix = '0;
  logic [7:0] b_z1, b_z2, b_z3, b_z4, b_z5, b_z6, b_z7, b_z8, b_z9;
  logic       b_win_valid, b_frame_done, b_busy;
  logic [8:0] b_win_x;
  logic [7:0] b_win_y;
  int         b_cnt = 0, b_fx = 0, b_fy = 0, b_lx = 0, b_ly = 0;
`endif

  always #5 clk = ~clk;

  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_in(pix_in), .pix_valid(pix_valid),
    .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7), .z8(z8), .z9(z9),
    .win_valid(win_valid), .frame_done(frame_done), .busy(busy)
`ifdef WINDOW_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

`ifdef WINDOW_COORD_EN
  window_gen_3x3 #(.IMG_WIDTH(320), .IMG_HEIGHT(240), .PIX_W(8)) dut_big (
    .clk(clk), .rst(rst), .frame_start(b_fs), .pix_in(b_pix), .pix_valid(b_pv),
    .z1(b_z1), .z2(b_z2), .z3(b_z3), .z4(b_z4), .z5(b_z5), .z6(b_z6), .z7(b_z7), .z8(b_z8), .z9(b_z9),
    .win_valid(b_win_valid), .frame_done(b_frame_done), .busy(b_busy),
    .win_x(b_win_x), .win_y(b_win_y)
  );
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: the whole frame is kept as a 2-D image, windows read straight from it.
  int   img [H][W];
  int   pos;
  logic in_frame;
  logic exp_valid, exp_done, exp_busy;
  int   exp_z [9];
  int   exp_x, exp_y;

  always @(posedge clk or posedge rst) begin : model
    int   p, r, c;
    logic acc;
    if (rst) begin
      in_frame  <= 1'b0;
      pos       <= 0;
      exp_valid <= 1'b0;
      exp_done  <= 1'b0;
      exp_busy  <= 1'b0;
      exp_x     <= 0;
      exp_y     <= 0;
      for (int k = 0; k < 9; k++) exp_z[k] <= 0;
    end else begin
      p   = frame_start ? 0 : pos;
      acc = pix_valid && (frame_start || in_frame);
      exp_valid <= 1'b0;
      exp_done  <= 1'b0;
      exp_busy  <= (frame_start || in_frame) && !(acc && p == W*H-1);
      if (frame_start) begin
        in_frame <= 1'b1;
        pos      <= 0;
      end
      if (acc) begin
        r = p / W;
        c = p % W;
        img[r][c] <= int'(pix_in);
        if (r >= 2 && c >= 2) begin
          exp_valid <= 1'b1;
          exp_x     <= c - 1;
          exp_y     <= r - 1;
          for (int k = 0; k < 9; k++)
            exp_z[k] <= (k == 8) ? int'(pix_in) : img[r-2+k/3][c-2+k%3];
        end
        pos <= p + 1;
        if (p == W*H-1) begin
          in_frame <= 1'b0;
          exp_done <= 1'b1;
        end
      end
    end
  end

  logic [7:0] zv [9];
  always_comb begin
    zv[0] = z1; zv[1] = z2; zv[2] = z3;
    zv[3] = z4; zv[4] = z5; zv[5] = z6;
    zv[6] = z7; zv[7] = z8; zv[8] = z9;
  end

  int win_cnt = 0, done_cnt = 0, done_with_valid = 0;
  int win_log [8][9];

  always @(negedge clk) begin
    chk("win_valid", int'(win_valid), int'(exp_valid));
    chk("frame_done", int'(frame_done), int'(exp_done));
    chk("busy", int'(busy), int'(exp_busy));
    for (int k = 0; k < 9; k++) chk($sformatf("z%0d", k+1), int'(zv[k]), exp_z[k]);
`ifdef WINDOW_COORD_EN
    if (win_valid) begin
      chk("win_x", int'(win_x), exp_x);
      chk("win_y", int'(win_y), exp_y);
    end
    if (b_win_valid) begin
      b_cnt++;
      if (b_cnt == 1) begin
        b_fx = int'(b_win_x);
        b_fy = int'(b_win_y);
      end
      b_lx = int'(b_win_x);
      b_ly = int'(b_win_y);
    end
`endif
    if (win_valid) begin
      if (win_cnt < 8)
        for (int k = 0; k < 9; k++) win_log[win_cnt][k] = int'(zv[k]);
      win_cnt++;
      if (frame_done) done_with_valid++;
    end
    if (frame_done) done_cnt++;
  end

  task automatic drive(input logic fs, input logic v, input int p);
    @(negedge clk);
    frame_start = fs;
    pix_valid   = v;
    pix_in      = p[7:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
  endtask

  task automatic send_frame(input int base, input bit gap);
    for (int i = 0; i < W*H; i++) begin
      drive(i == 0, 1'b1, base + i);
      if (gap) drive(1'b0, 1'b0, 0);
    end
    idle(3);
  endtask

  task automatic clear_log();
    win_cnt = 0;
    done_cnt = 0;
    done_with_valid = 0;
  endtask

  // Literal 4x3 windows: z_k = base + row*4 + col, window anchored at column `base`.
  task automatic check_win(input string tag, input int idx, input int base);
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s_w%0d_z%0d", tag, idx, k+1), win_log[idx][k], base + (k/3)*4 + k%3);
  endtask

  task automatic check_frame(input string tag, input int base, input int n_done);
    chk({tag, "_win_cnt"}, win_cnt, 2);
    chk({tag, "_done_cnt"}, done_cnt, n_done);
    chk({tag, "_done_with_valid"}, done_with_valid, n_done);
    check_win(tag, 0, base);
    check_win(tag, 1, base + 1);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_z5", int'(z5), 0);

    clear_log();
    send_frame(0, 1'b0);
    check_frame("b2b", 0, 1);

    clear_log();
    send_frame(0, 1'b1);
    check_frame("gap", 0, 1);

    clear_log();
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 50 + i);
    idle(2);
    chk("idle_win_cnt", win_cnt, 0);
    chk("idle_busy", int'(busy), 0);
    send_frame(0, 1'b0);
    check_frame("after_idle", 0, 1);

    clear_log();
    for (int i = 0; i < 6; i++) drive(i == 0, 1'b1, i);
    send_frame(100, 1'b0);
    check_frame("abort", 100, 1);

    clear_log();
    for (int i = 0; i < 11; i++) drive(i == 0, 1'b1, 20 + i);
    @(posedge clk);
    #2;
    rst = 1'b1;
    pix_valid = 1'b0;
    #1;
    chk("arst_win_valid", int'(win_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_z9", int'(z9), 0);
    chk("arst_z1", int'(z1), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    clear_log();
    send_frame(0, 1'b0);
    check_frame("post_rst", 0, 1);

`ifdef WINDOW_COORD_EN
    for (int i = 0; i < 320*240; i++) begin
      @(negedge clk);
      b_fs  = (i == 0);
      b_pv  = 1'b1;
      b_pix = i[7:0];
    end
    @(negedge clk);
    b_fs = 1'b0;
    b_pv = 1'b0;
    idle(3);
    chk("big_win_cnt", b_cnt, 318*238);
    chk("big_first_x", b_fx, 1);
    chk("big_first_y", b_fy, 1);
    chk("big_last_x", b_lx, 318);
    chk("big_last_y", b_ly, 238);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
